mem_responder: RTL and testbench

- Memory-side responder for the multicycle CPU's data/instruction memory port: the slave end of the CPU's memory request.
- Accepts word-aligned read/write requests with byte enables.
- Inserts a programmable number of wait states, then returns data and a one-cycle `ready` pulse.
- Sits between the CPU's address/write-data path and a local word array, replacing the fixed-latency memory where variable latency must be exercised.

---
 rtl/mem_responder.sv | 159 +++++++++++++++
 tb/tb_mem_responder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Variable-latency word memory responder: accepts one request, waits WAIT_CYCLES, pulses ready.
// Define MEM_RESP_ERR_EN to flag misaligned or out-of-range addresses via addr_err.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        addr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        addr_err_q, addr_err_d;

    logic        accept;
    logic        enter_resp;
    logic        acc_wr;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic [AW-1:0] acc_idx;
    logic        acc_err;
    logic        resp_err;
    logic        mem_we;
    logic        mem_re;
    logic [3:0][7:0] rd_word;

    // With zero wait states the array is accessed on the accepting edge, so use the live inputs.
    assign accept    = (state_q == S_IDLE) && req;
    assign acc_wr    = accept ? wr    : wr_q;
    assign acc_addr  = accept ? addr  : addr_q;
    assign acc_wdata = accept ? wdata : wdata_q;
    assign acc_be    = accept ? be    : be_q;
    assign acc_idx   = acc_addr[AW+1:2];

`ifdef MEM_RESP_ERR_EN
    assign acc_err  = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
    assign resp_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[1:0], acc_addr[31:AW+2]};
    assign acc_err  = 1'b0;
    assign resp_err = 1'b0;
`endif

    assign enter_resp = !reset && (state_d == S_RESP) && (state_q != S_RESP);
    assign mem_we     = enter_resp && acc_wr && !acc_err;
    assign mem_re     = enter_resp && !acc_wr;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_q [DEPTH_WORDS];
            logic [7:0] rd_byte_q;

            always_ff @(posedge clock) begin
                if (mem_we && acc_be[gi]) begin
                    lane_q[acc_idx] <= acc_wdata[gi*8 +: 8];
                end
                if (mem_re) begin
                    rd_byte_q <= lane_q[acc_idx];
                end
            end

            assign rd_word[gi] = rd_byte_q;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        addr_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // Outputs are registered, so the pulse appears in the cycle after RESP.
                state_d    = S_IDLE;
                ready_d    = 1'b1;
                addr_err_d = resp_err;
                if (!wr_q && !resp_err) begin
                    rdata_d = rd_word;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            rdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (0, 1 and 3 wait states) against a word-array model.
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int W1    = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1, req3;
    logic        wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] rdata0, rdata1, rdata3;
    logic        ready0, ready1, ready3;
    logic        err0, err1, err3;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;
    int          cur_sel;

    logic [31:0] s_rdata;
    logic        s_ready, s_err;

    always #5 clock = ~clock;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u0 (
        .clock(clock), .reset(reset), .req(req0), .wr(wr), .addr(addr), .wdata(wdata),
        .be(be), .rdata(rdata0), .ready(ready0), .addr_err(err0));
    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) u1 (
        .clock(clock), .reset(reset), .req(req1), .wr(wr), .addr(addr), .wdata(wdata),
        .be(be), .rdata(rdata1), .ready(ready1), .addr_err(err1));
    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u3 (
        .clock(clock), .reset(reset), .req(req3), .wr(wr), .addr(addr), .wdata(wdata),
        .be(be), .rdata(rdata3), .ready(ready3), .addr_err(err3));

    assign s_rdata = (cur_sel == 0) ? rdata0 : (cur_sel == 3) ? rdata3 : rdata1;
    assign s_ready = (cur_sel == 0) ? ready0 : (cur_sel == 3) ? ready3 : ready1;
    assign s_err   = (cur_sel == 0) ? err0   : (cur_sel == 3) ? err3   : err1;

    function automatic int widx(input logic [31:0] a);
        return int'(a >> 2) % DEPTH;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        int i;
        i = widx(a);
        for (int l = 0; l < 4; l++) begin
            if (b[l]) model_mem[i][l*8 +: 8] = d[l*8 +: 8];
        end
    endfunction

    // One request on the selected instance; lat = edges from acceptance to ready (-1 if none within 40).
    task automatic do_access(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, output logic [31:0] rd, output logic er,
                             output int lat, output logic width_ok);
        cur_sel = sel;
        @(negedge clock);
        wr = w; addr = a; wdata = d; be = b;
        if (sel == 0) req0 = 1'b1; else if (sel == 3) req3 = 1'b1; else req1 = 1'b1;
        @(posedge clock);
        #1;
        req0 = 1'b0; req1 = 1'b0; req3 = 1'b0;
        lat = -1; rd = 32'hx; er = 1'bx; width_ok = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (s_ready === 1'b1) begin
                lat = k; rd = s_rdata; er = s_err;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clock);
            #1;
            width_ok = (s_ready === 1'b0);
        end
        $display("txn sel=%0d wr=%0d addr=%h wdata=%h be=%h -> rdata=%h err=%0d lat=%0d",
                 sel, w, a, d, b, rd, er, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; req3 = 1'b0;
        wr = 1'b0; addr = '0; wdata = '0; be = '0;
        cur_sel = 1;
        model_rdata = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (ready1 !== 1'b0 || err1 !== 1'b0 || rdata1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b err=%b rdata=%h, want 0 0 00000000", ready1, err1, rdata1);
        end
        checks++;
        if (ready0 !== 1'b0 || ready3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_others: ready0=%b ready3=%b, want 0 0", ready0, ready3);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er, wok; int lat;
        do_access(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, wok);
        model_write(32'h10, 32'hDEADBEEF, 4'hF);
        checks++;
        if (lat !== W1 + 1 || wok !== 1'b1 || er !== 1'b0) begin
            errors++;
            $display("FAIL wr_latency: lat=%0d width_ok=%b err=%b, want %0d 1 0", lat, wok, er, W1 + 1);
        end
        do_access(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, wok);
        model_rdata = model_mem[widx(32'h10)];
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== W1 + 1) begin
            errors++;
            $display("FAIL rd_after_wr: rdata=%h err=%b lat=%0d, want deadbeef 0 %0d", rd, er, lat, W1 + 1);
        end
    endtask

    task automatic test_byte_lane();
        logic [31:0] rd; logic er, wok; int lat;
        do_access(1, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat, wok);
        model_write(32'h20, 32'h11223344, 4'hF);
        do_access(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat, wok);
        model_write(32'h20, 32'hAABBCCDD, 4'b0101);
        checks++;
        if (rd !== model_rdata) begin
            errors++;
            $display("FAIL write_keeps_rdata: rdata=%h, want %h", rd, model_rdata);
        end
        do_access(1, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, wok);
        model_rdata = model_mem[widx(32'h20)];
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_lane: rdata=%h, want 11bb33dd", rd);
        end
        do_access(1, 1'b1, 32'h24, 32'h55667788, 4'b0000, rd, er, lat, wok);
        checks++;
        if (lat !== W1 + 1 || er !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_ready: lat=%0d err=%b, want %0d 0", lat, er, W1 + 1);
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd, v; logic er, wok; int lat;
        int sels [2] = '{0, 3};
        for (int s = 0; s < 2; s++) begin
            v = $urandom;
            do_access(sels[s], 1'b1, 32'h40, v, 4'hF, rd, er, lat, wok);
            checks++;
            if (lat !== sels[s] + 1 || wok !== 1'b1) begin
                errors++;
                $display("FAIL latency_wr_w%0d: lat=%0d width_ok=%b, want %0d 1", sels[s], lat, wok, sels[s] + 1);
            end
            do_access(sels[s], 1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat, wok);
            checks++;
            if (lat !== sels[s] + 1 || wok !== 1'b1 || rd !== v) begin
                errors++;
                $display("FAIL latency_rd_w%0d: lat=%0d width_ok=%b rdata=%h, want %0d 1 %h",
                         sels[s], lat, wok, rd, sels[s] + 1, v);
            end
        end
    endtask

    task automatic test_req_held();
        int  n_ready;
        logic exp;
        n_ready = 0;
        cur_sel = 1;
        @(negedge clock);
        wr = 1'b0; addr = 32'h10; be = 4'hF;
        req1 = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clock);
            #1;
            exp = (k >= W1 + 2) && (((k - (W1 + 2)) % (W1 + 2)) == 0);
            if (ready1 === 1'b1) n_ready++;
            checks++;
            if (ready1 !== exp) begin
                errors++;
                $display("FAIL req_held_edge%0d: ready=%b, want %b", k, ready1, exp);
            end
        end
        req1 = 1'b0;
        model_rdata = model_mem[widx(32'h10)];
        $display("txn req_held reads=%0d rdata=%h", n_ready, rdata1);
        checks++;
        if (n_ready != 30 / (W1 + 2) || rdata1 !== model_rdata) begin
            errors++;
            $display("FAIL req_held_count: readies=%0d rdata=%h, want %0d %h", n_ready, rdata1, 30 / (W1 + 2), model_rdata);
        end
        repeat (4) @(posedge clock);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, wok; int lat; int seen;
        do_access(1, 1'b1, 32'h30, 32'h0, 4'hF, rd, er, lat, wok);
        model_write(32'h30, 32'h0, 4'hF);
        cur_sel = 1;
        @(negedge clock);
        wr = 1'b1; addr = 32'h30; wdata = 32'hFFFFFFFF; be = 4'hF;
        req1 = 1'b1;
        @(posedge clock);
        #1;
        req1 = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        model_rdata = 32'd0;
        checks++;
        if (ready1 !== 1'b0 || err1 !== 1'b0 || rdata1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: ready=%b err=%b rdata=%h, want 0 0 00000000", ready1, err1, rdata1);
        end
        seen = 0;
        repeat (2) begin
            @(posedge clock); #1;
            if (ready1 === 1'b1) seen++;
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            if (ready1 === 1'b1) seen++;
        end
        $display("txn reset_mid spurious_ready=%0d", seen);
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_no_ready: ready pulses=%0d, want 0", seen);
        end
        do_access(1, 1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat, wok);
        model_rdata = model_mem[widx(32'h30)];
        checks++;
        if (rd !== 32'h0 || lat !== W1 + 1) begin
            errors++;
            $display("FAIL reset_mid_discard: rdata=%h lat=%0d, want 00000000 %0d", rd, lat, W1 + 1);
        end
    endtask

    task automatic test_addr_err();
        logic [31:0] rd; logic er, wok; int lat;
        do_access(1, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat, wok);
        model_write(32'h0, 32'hCAFEF00D, 4'hF);
        do_access(1, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat, wok);
        model_rdata = model_mem[widx(32'h10)];
`ifdef MEM_RESP_ERR_EN
        do_access(1, 1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat, wok);
        checks++;
        if (er !== 1'b1 || rd !== model_rdata || lat !== W1 + 1) begin
            errors++;
            $display("FAIL err_misaligned_rd: err=%b rdata=%h lat=%0d, want 1 %h %0d", er, rd, lat, model_rdata, W1 + 1);
        end
        do_access(1, 1'b1, 32'h400, 32'h12345678, 4'hF, rd, er, lat, wok);
        checks++;
        if (er !== 1'b1 || lat !== W1 + 1) begin
            errors++;
            $display("FAIL err_range_wr: err=%b lat=%0d, want 1 %0d", er, lat, W1 + 1);
        end
`else
        do_access(1, 1'b1, 32'h400, 32'h12345678, 4'hF, rd, er, lat, wok);
        model_write(32'h400, 32'h12345678, 4'hF);
        checks++;
        if (er !== 1'b0 || lat !== W1 + 1) begin
            errors++;
            $display("FAIL wrap_wr: err=%b lat=%0d, want 0 %0d", er, lat, W1 + 1);
        end
`endif
        do_access(1, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat, wok);
        model_rdata = model_mem[0];
        checks++;
        if (rd !== model_mem[0] || er !== 1'b0) begin
            errors++;
            $display("FAIL mem0_after_400: rdata=%h err=%b, want %h 0", rd, er, model_mem[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d; logic er, wok, w; logic [3:0] b; int lat, idx;
        for (int i = 64; i < 96; i++) begin
            d = $urandom;
            do_access(1, 1'b1, 32'(i) << 2, d, 4'hF, rd, er, lat, wok);
            model_write(32'(i) << 2, d, 4'hF);
        end
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(64, 95);
`ifdef MEM_RESP_ERR_EN
            a = 32'(idx) << 2;
`else
            a = $urandom;
            a[9:2] = idx[7:0];
`endif
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            do_access(1, w, a, d, b, rd, er, lat, wok);
            if (w) model_write(a, d, b);
            else model_rdata = model_mem[idx];
            checks++;
            if (rd !== model_rdata || er !== 1'b0 || lat !== W1 + 1 || wok !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d: rdata=%h err=%b lat=%0d width_ok=%b, want %h 0 %0d 1",
                         n, rd, er, lat, wok, model_rdata, W1 + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lane();
        test_latency();
        test_req_held();
        test_reset_mid();
        test_addr_err();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
